// File: rtl/seg_pkg.sv
// Shared types and constants for the four-digit
// multiplexed BCD display scanner.
package seg_pkg;

  typedef enum logic {
    SHOW  = 1'b0,
    GUARD = 1'b1
  } state_e;

  localparam int          NUM_DIG = 4;
  localparam logic [3:0]  DIG_OFF = 4'b1111;
  localparam logic [3:0]  BCD_MAX = 4'd9;

endpackage

// File: rtl/seg_blank_mask.sv
// Per-digit blank mask: non-BCD nibbles are always
// blanked, leading zeros only when blanking is enabled.
import seg_pkg::*;

module seg_blank_mask (
  input  logic [15:0]        iShadow,
  input  logic               iLzb,
  output logic [NUM_DIG-1:0] oMask
);

  logic [3:0] nib3, nib2, nib1, nib0;
  logic       z3, z2, z1;

  assign nib3 = iShadow[15:12];
  assign nib2 = iShadow[11:8];
  assign nib1 = iShadow[7:4];
  assign nib0 = iShadow[3:0];

  // zN: nibbles N..3 are all zero, so digit N is a leading zero
  always_comb begin
    z3 = (nib3 == 4'd0);
    z2 = z3 && (nib2 == 4'd0);
    z1 = z2 && (nib1 == 4'd0);
    oMask[3] = (nib3 > BCD_MAX) || (iLzb && z3);
    oMask[2] = (nib2 > BCD_MAX) || (iLzb && z2);
    oMask[1] = (nib1 > BCD_MAX) || (iLzb && z1);
    oMask[0] = (nib0 > BCD_MAX);
  end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed scanner for a 4-digit display with
// guard gaps and frame-aligned (tear-free) value updates.
import seg_pkg::*;

module seg_scan #(
  parameter int DIG_CYC   = 50000,
  parameter int GUARD_CYC = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] iBCD,
  input  logic        iValid,
  output logic        oReady,
  input  logic        iLzb,
  output logic [3:0]  oDEC,
  output logic [3:0]  oDIG,
  output logic        oFrame
);

  localparam int CNT_MAX =
    (DIG_CYC > GUARD_CYC) ? DIG_CYC : GUARD_CYC;
  localparam int CNT_W =
    (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(DIG_CYC - 1);
  localparam logic [CNT_W-1:0] GRD_LAST = CNT_W'(GUARD_CYC - 1);
  localparam logic [1:0]       IDX_LAST = 2'(NUM_DIG - 1);

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [15:0]      pending_q, pending_d;
  logic             pend_q, pend_d;

  logic             frame_end;
  logic             xfer;
  logic [NUM_DIG-1:0] mask;

  seg_blank_mask u_mask (
    .iShadow (shadow_q),
    .iLzb    (iLzb),
    .oMask   (mask)
  );

  assign frame_end = (state_q == GUARD) && (idx_q == IDX_LAST)
                  && (cnt_q == GRD_LAST);
  assign xfer = iValid && !pend_q;

  // all state held in async-reset flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= GUARD;
      idx_q     <= IDX_LAST;
      cnt_q     <= '0;
      shadow_q  <= '0;
      pending_q <= '0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      pend_q    <= pend_d;
    end
  end

  // scan sequencer: SHOW a digit, then GUARD all-off, next digit
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + 1'b1;
    unique case (state_q)
      SHOW: begin
        if (cnt_q == DIG_LAST) begin
          state_d = GUARD;
          cnt_d   = '0;
        end
      end
      GUARD: begin
        if (cnt_q == GRD_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
        end
      end
      default: begin
        state_d = GUARD;
        cnt_d   = '0;
      end
    endcase
  end

  // value path: shadow only moves at frame end, one-deep buffer
  always_comb begin
    shadow_d  = shadow_q;
    pending_d = pending_q;
    pend_d    = pend_q;
    if (frame_end) begin
      if (xfer) begin
        shadow_d = iBCD;
      end else if (pend_q) begin
        shadow_d = pending_q;
        pend_d   = 1'b0;
      end
    end else if (xfer) begin
      pending_d = iBCD;
      pend_d    = 1'b1;
    end
  end

  // outputs decoded from registers and live blanking enable
  always_comb begin
    oReady = !pend_q;
    oFrame = frame_end && !rst;
    oDEC   = shadow_q[{idx_q, 2'b00} +: 4];
    oDIG   = DIG_OFF;
    if ((state_q == SHOW) && !mask[idx_q]) begin
      oDIG = ~(4'b0001 << idx_q);
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan with a per-cycle
// scoreboard driven by an independent timeline model.
module tb_seg_scan;

  localparam int DC = 4;
  localparam int GC = 2;
  localparam int SLOT = DC + GC;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] iBCD = '0;
  logic        iValid = 1'b0;
  logic        oReady;
  logic        iLzb = 1'b0;
  logic [3:0]  oDEC;
  logic [3:0]  oDIG;
  logic        oFrame;

  int vectors = 0;
  int miscompares = 0;

  int          n;
  logic [15:0] m_shadow;
  logic [15:0] m_pending;
  logic        m_pend;

  logic [9:0]  sb_q[$];

  seg_scan #(.DIG_CYC(DC), .GUARD_CYC(GC)) dut (
    .clk    (clk),
    .rst    (rst),
    .iBCD   (iBCD),
    .iValid (iValid),
    .oReady (oReady),
    .iLzb   (iLzb),
    .oDEC   (oDEC),
    .oDIG   (oDIG),
    .oFrame (oFrame)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [9:0] got, logic [9:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got dig=%b dec=%h frm=%b rdy=%b exp dig=%b dec=%h frm=%b rdy=%b",
               tag, got[9:6], got[5:2], got[1], got[0],
               exp[9:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  function automatic int phase(int k);
    return (k + FRAME - GC) % FRAME;
  endfunction

  function automatic logic [9:0] model_out(int k, logic [15:0] sh,
                                           logic pd, logic lzb);
    int m, d, w;
    logic [3:0] nib, dig;
    logic blank;
    m = phase(k);
    d = m / SLOT;
    w = m % SLOT;
    nib = sh[d*4 +: 4];
    blank = (nib > 4'd9) || (d > 0 && lzb && ((sh >> (4*d)) == 16'd0));
    dig = (w < DC && !blank) ? ~(4'b0001 << d) : 4'b1111;
    return {dig, nib, (m == FRAME - 1), !pd};
  endfunction

  function automatic logic [9:0] dut_out();
    return {oDIG, oDEC, oFrame, oReady};
  endfunction

  // one clock: drive at negedge, compare, advance model at posedge
  task automatic step(logic v, logic [15:0] bcd, logic lzb, string tag);
    logic fe, x;
    iValid = v;
    iBCD   = bcd;
    iLzb   = lzb;
    sb_q.push_back(model_out(n, m_shadow, m_pend, lzb));
    #1;
    chk($sformatf("%s@%0d", tag, n), dut_out(), sb_q.pop_front());
    fe = (phase(n) == FRAME - 1);
    x  = v && !m_pend;
    @(posedge clk);
    if (fe) begin
      if (x) m_shadow = bcd;
      else if (m_pend) begin
        m_shadow = m_pending;
        m_pend = 1'b0;
      end
    end else if (x) begin
      m_pending = bcd;
      m_pend = 1'b1;
    end
    n++;
    @(negedge clk);
  endtask

  task automatic idle(int cycles, logic lzb, string tag);
    for (int i = 0; i < cycles; i++) step(1'b0, 16'h0, lzb, tag);
  endtask

  // called at a negedge; asserts reset, checks, releases
  task automatic do_reset(string tag);
    iValid = 1'b0;
    rst = 1'b1;
    #1;
    chk({tag, "_now"}, dut_out(), {4'b1111, 4'h0, 1'b0, 1'b1});
    @(negedge clk);
    chk({tag, "_hold"}, dut_out(), {4'b1111, 4'h0, 1'b0, 1'b1});
    rst = 1'b0;
    n = 0;
    m_shadow = '0;
    m_pending = '0;
    m_pend = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset("rst0");
    idle(30, 1'b0, "idle");

    // mid-frame load, display begins only at next frame
    idle(5, 1'b0, "pre1234");
    step(1'b1, 16'h1234, 1'b0, "ld1234");
    idle(2 * FRAME, 1'b0, "sh1234");

    // back-to-back offers: second dropped while pending
    step(1'b1, 16'h1111, 1'b0, "ld1111");
    step(1'b1, 16'h2222, 1'b0, "ld2222");
    idle(2 * FRAME, 1'b0, "sh1111");

    // offer exactly on the frame-end cycle
    while (phase(n) != FRAME - 1) step(1'b0, 16'h0, 1'b0, "align");
    step(1'b1, 16'h5678, 1'b0, "ldfe");
    idle(FRAME, 1'b0, "sh5678");

    // leading-zero blanking on and off
    step(1'b1, 16'h0050, 1'b1, "ld0050");
    idle(2 * FRAME, 1'b1, "lzb1");
    idle(FRAME, 1'b0, "lzb0");

    // invalid nibble blanking, then async reset mid-SHOW
    step(1'b1, 16'h00A0, 1'b0, "ld00A0");
    idle(FRAME + 4, 1'b0, "sh00A0");
    while (!(m_shadow == 16'h00A0 && (phase(n) % SLOT) == 1))
      step(1'b0, 16'h0, 1'b0, "alignrst");
    do_reset("rst1");
    idle(FRAME + 4, 1'b0, "postrst");

    // random traffic with live blanking toggles
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 3) == 0), 16'($urandom),
           1'($urandom_range(0, 1)), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
